// File: rtl/kf_crtc_timing_core_if.sv
// Register-file bus between the host decoder and the CRTC timing core.
interface kf_crtc_timing_core_if;
  logic        reg_write;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  modport master (output reg_write, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_write, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/kf_crtc_timing_core.sv
// CRT timing/address core: HSYNC/VSYNC/DE/RA/MA/CURSOR from a shadowed register file.
// Optional feature: define CURSOR_BLINK_EN for field-counted cursor blink.
module kf_crtc_timing_core #(
  parameter int H_WIDTH  = 8,
  parameter int V_WIDTH  = 7,
  parameter int RA_WIDTH = 5,
  parameter int MA_WIDTH = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   video_clock_enable,
  kf_crtc_timing_core_if.slave   bus,
  output logic                   HSYNC,
  output logic                   VSYNC,
  output logic                   DE,
  output logic [RA_WIDTH-1:0]    RA,
  output logic [MA_WIDTH-1:0]    MA,
  output logic                   CURSOR,
  output logic                   frame_start
);

  typedef struct packed {
    logic [H_WIDTH-1:0]  htot;
    logic [H_WIDTH-1:0]  hdisp;
    logic [H_WIDTH-1:0]  hsp;
    logic [H_WIDTH-1:0]  hsw;
    logic [V_WIDTH-1:0]  vtot;
    logic [RA_WIDTH-1:0] vadj;
    logic [V_WIDTH-1:0]  vdisp;
    logic [V_WIDTH-1:0]  vsp;
    logic [3:0]          vsw;
    logic [RA_WIDTH-1:0] maxs;
    logic [MA_WIDTH-1:0] start;
  } tim_t;

  typedef enum logic {ST_ACTIVE, ST_ADJUST} state_t;

  localparam logic [H_WIDTH-1:0]  H_ONE  = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0]  V_ONE  = V_WIDTH'(1);
  localparam logic [RA_WIDTH-1:0] RA_ONE = RA_WIDTH'(1);

  tim_t                pend_q, pend_d, act_q;
  logic [MA_WIDTH-1:0] caddr_q, caddr_d;
  logic [RA_WIDTH-1:0] cs_line_q, cs_line_d, ce_line_q, ce_line_d;
  logic [1:0]          cs_mode_q, cs_mode_d;
  logic [2:0]          ctrl_q, ctrl_d;

  state_t              state_q, state_d;
  logic [H_WIDTH-1:0]  hc_q, hc_d;
  logic [V_WIDTH-1:0]  vc_q, vc_d;
  logic [RA_WIDTH-1:0] ra_q, ra_d;
  logic [MA_WIDTH-1:0] rb_q, rb_d;
  logic [3:0]          vsl_q, vsl_d;
  logic                vsln_q, vsln_d;

  logic                hsync_q, vsync_q, de_q, cursor_q, fs_q;
  logic [RA_WIDTH-1:0] ra_out_q;
  logic [MA_WIDTH-1:0] ma_out_q;

  logic                line_end, line_start, vs_start, vs_line, frame_wrap;
  logic                de, hs, cur, fs, blink_on;
  logic [MA_WIDTH-1:0] ma;
  logic [H_WIDTH:0]    hs_end;

  // Register writes: shadowed timing regs land in pend_*, cursor/control act at once.
  always_comb begin
    pend_d    = pend_q;
    caddr_d   = caddr_q;
    cs_line_d = cs_line_q;
    cs_mode_d = cs_mode_q;
    ce_line_d = ce_line_q;
    ctrl_d    = ctrl_q;
    if (bus.reg_write) begin
      case (bus.reg_addr)
        4'd0:  pend_d.htot  = H_WIDTH'(bus.reg_wdata);
        4'd1:  pend_d.hdisp = H_WIDTH'(bus.reg_wdata);
        4'd2:  pend_d.hsp   = H_WIDTH'(bus.reg_wdata);
        4'd3:  pend_d.hsw   = H_WIDTH'(bus.reg_wdata);
        4'd4:  pend_d.vtot  = V_WIDTH'(bus.reg_wdata);
        4'd5:  pend_d.vadj  = RA_WIDTH'(bus.reg_wdata);
        4'd6:  pend_d.vdisp = V_WIDTH'(bus.reg_wdata);
        4'd7:  pend_d.vsp   = V_WIDTH'(bus.reg_wdata);
        4'd8:  pend_d.vsw   = 4'(bus.reg_wdata);
        4'd9:  pend_d.maxs  = RA_WIDTH'(bus.reg_wdata);
        4'd10: pend_d.start = MA_WIDTH'(bus.reg_wdata);
        4'd11: caddr_d      = MA_WIDTH'(bus.reg_wdata);
        4'd12: begin
          cs_line_d = RA_WIDTH'(bus.reg_wdata);
          cs_mode_d = bus.reg_wdata[6:5];
        end
        4'd13: ce_line_d    = RA_WIDTH'(bus.reg_wdata);
        4'd14: ctrl_d       = 3'(bus.reg_wdata);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      4'd0:  bus.reg_rdata = 16'(pend_q.htot);
      4'd1:  bus.reg_rdata = 16'(pend_q.hdisp);
      4'd2:  bus.reg_rdata = 16'(pend_q.hsp);
      4'd3:  bus.reg_rdata = 16'(pend_q.hsw);
      4'd4:  bus.reg_rdata = 16'(pend_q.vtot);
      4'd5:  bus.reg_rdata = 16'(pend_q.vadj);
      4'd6:  bus.reg_rdata = 16'(pend_q.vdisp);
      4'd7:  bus.reg_rdata = 16'(pend_q.vsp);
      4'd8:  bus.reg_rdata = 16'(pend_q.vsw);
      4'd9:  bus.reg_rdata = 16'(pend_q.maxs);
      4'd10: bus.reg_rdata = 16'(pend_q.start);
      4'd11: bus.reg_rdata = 16'(caddr_q);
      4'd12: bus.reg_rdata = 16'({cs_mode_q, 5'(cs_line_q)});
      4'd13: bus.reg_rdata = 16'(ce_line_q);
      4'd14: bus.reg_rdata = 16'(ctrl_q);
      default: ;
    endcase
  end

  // VSYNC is decided at hc==0 and held for the line; a new start restarts the count.
  assign line_end   = (hc_q >= act_q.htot);
  assign line_start = (hc_q == '0);
  assign vs_start   = line_start && (state_q == ST_ACTIVE) && (vc_q == act_q.vsp) && (ra_q == '0);
  assign vs_line    = vs_start || (line_start ? (vsl_q != '0) : vsln_q);

  always_comb begin
    state_d    = state_q;
    hc_d       = hc_q;
    vc_d       = vc_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    vsl_d      = vsl_q;
    vsln_d     = vsln_q;
    frame_wrap = 1'b0;
    if (line_start) begin
      vsln_d = vs_line;
      if (vs_start)            vsl_d = act_q.vsw - 4'd1;  // width 0 wraps to 15 more = 16 lines
      else if (vsl_q != '0)    vsl_d = vsl_q - 4'd1;
    end
    if (!line_end) begin
      hc_d = hc_q + H_ONE;
    end else begin
      hc_d = '0;
      case (state_q)
        ST_ACTIVE: begin
          if (ra_q == act_q.maxs) begin
            ra_d = '0;
            if (vc_q == act_q.vtot) begin
              if (act_q.vadj != '0) state_d = ST_ADJUST;
              else                  frame_wrap = 1'b1;
            end else begin
              vc_d = vc_q + V_ONE;
              rb_d = rb_q + MA_WIDTH'(act_q.hdisp);
            end
          end else begin
            ra_d = ra_q + RA_ONE;
          end
        end
        default: begin
          if (ra_q == act_q.vadj - RA_ONE) frame_wrap = 1'b1;
          else                             ra_d = ra_q + RA_ONE;
        end
      endcase
    end
    if (frame_wrap) begin
      state_d = ST_ACTIVE;
      vc_d    = '0;
      ra_d    = '0;
      rb_d    = pend_d.start;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [4:0] fld_q;
  logic       slow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fld_q  <= '0;
      slow_q <= 1'b0;
    end else if (video_clock_enable && frame_wrap) begin
      fld_q  <= fld_q + 5'd1;
      slow_q <= slow_q ^ (fld_q == 5'd31);
    end
  end

  always_comb begin
    case (cs_mode_q)
      2'b00:   blink_on = 1'b1;
      2'b01:   blink_on = 1'b0;
      2'b10:   blink_on = ~fld_q[4];
      default: blink_on = ~slow_q;
    endcase
  end
`else
  assign blink_on = 1'b1;
`endif

  assign ma     = rb_q + MA_WIDTH'(hc_q);
  assign de     = (hc_q < act_q.hdisp) && (vc_q < act_q.vdisp) && (state_q == ST_ACTIVE);
  assign hs_end = {1'b0, act_q.hsp} + {1'b0, act_q.hsw};
  assign hs     = (hc_q >= act_q.hsp) && ({1'b0, hc_q} < hs_end);
  assign cur    = ctrl_q[2] && de && (ma == caddr_q) && (cs_line_q <= ra_q) &&
                  (ra_q <= ce_line_q) && blink_on;
  assign fs     = line_start && (vc_q == '0) && (ra_q == '0) && (state_q == ST_ACTIVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      act_q     <= '0;
      caddr_q   <= '0;
      cs_line_q <= '0;
      cs_mode_q <= '0;
      ce_line_q <= '0;
      ctrl_q    <= '0;
      state_q   <= ST_ACTIVE;
      hc_q      <= '0;
      vc_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      vsl_q     <= '0;
      vsln_q    <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      cursor_q  <= 1'b0;
      fs_q      <= 1'b0;
      ra_out_q  <= '0;
      ma_out_q  <= '0;
    end else begin
      pend_q    <= pend_d;
      caddr_q   <= caddr_d;
      cs_line_q <= cs_line_d;
      cs_mode_q <= cs_mode_d;
      ce_line_q <= ce_line_d;
      ctrl_q    <= ctrl_d;
      if (video_clock_enable) begin
        state_q  <= state_d;
        hc_q     <= hc_d;
        vc_q     <= vc_d;
        ra_q     <= ra_d;
        rb_q     <= rb_d;
        vsl_q    <= vsl_d;
        vsln_q   <= vsln_d;
        if (frame_wrap) act_q <= pend_d;
        hsync_q  <= hs ^ ctrl_q[0];
        vsync_q  <= vs_line ^ ctrl_q[1];
        de_q     <= de;
        cursor_q <= cur;
        fs_q     <= fs;
        ra_out_q <= ra_q;
        ma_out_q <= ma;
      end
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign CURSOR      = cursor_q;
  assign frame_start = fs_q;
  assign RA          = ra_out_q;
  assign MA          = ma_out_q;

endmodule
